// File: rtl/message_build.sv
// SHA-256 message padder: packs a 32-bit big-endian word stream into 512-bit blocks,
// appending the 0x80 marker, zero fill and the 64-bit bit length of the message.
module message_build #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         sync_rst,
    input  logic [31:0]  data_in,
    input  logic [1:0]   data_in_nbytes,
    input  logic         data_in_last,
    input  logic         data_in_valid,
    output logic         data_in_ready,
    output logic [511:0] data_out,
    output logic         data_out_last,
    output logic         data_out_valid,
    input  logic         data_out_ready
);

    typedef enum logic [1:0] {COLLECT, OUT, EXTRA} state_t;
    typedef enum logic [1:0] {PAD_NONE, PAD_LEN_ONLY, PAD_MARK_LEN} pad_t;

    state_t                  state_q, state_d;
    pad_t                    pad_q, pad_d;
    logic [3:0]              word_idx_q, word_idx_d;
    logic [LEN_W-1:0]        bit_len_q, bit_len_d;
    logic [15:0][31:0]       blk_q, blk_d;
    logic                    last_q, last_d;

    logic [5:0]              add_bits;
    logic [LEN_W-1:0]        len_new;
    logic [63:0]             len_field;
    logic [63:0]             len_field_q;
    logic [31:0]             last_word;
    logic                    full_word;
    logic [4:0]              pad_pos;

    always_comb begin
        full_word = (data_in_nbytes == 2'd0);
        add_bits  = data_in_last ? (full_word ? 6'd32 : {1'b0, data_in_nbytes, 3'b000}) : 6'd32;
        len_new   = bit_len_q + LEN_W'(add_bits);
        len_field   = 64'(len_new);
        len_field_q = 64'(bit_len_q);
        // The marker byte lands right after the last valid byte of a partial word.
        case (data_in_nbytes)
            2'd1:    last_word = {data_in[31:24], 8'h80, 16'h0000};
            2'd2:    last_word = {data_in[31:16], 8'h80, 8'h00};
            2'd3:    last_word = {data_in[31:8], 8'h80};
            default: last_word = data_in;
        endcase
        pad_pos = full_word ? {1'b0, word_idx_q} + 5'd1 : {1'b0, word_idx_q};
    end

    // NOTE: next-state logic assigns every output a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pad_d      = pad_q;
        word_idx_d = word_idx_q;
        bit_len_d  = bit_len_q;
        blk_d      = blk_q;
        last_d     = last_q;
        unique case (state_q)
            COLLECT: begin
                if (data_in_valid) begin
                    bit_len_d = len_new;
                    if (!data_in_last) begin
                        blk_d[word_idx_q] = data_in;
                        word_idx_d        = word_idx_q + 4'd1;
                        if (word_idx_q == 4'd15) begin
                            state_d = OUT;
                            last_d  = 1'b0;
                        end
                    end else begin
                        for (int k = 0; k < 16; k++) begin
                            if (4'(k) == word_idx_q)  blk_d[k] = last_word;
                            else if (5'(k) == pad_pos) blk_d[k] = 32'h8000_0000;
                            else if (5'(k) > pad_pos)  blk_d[k] = 32'h0000_0000;
                        end
                        if (pad_pos <= 5'd13) begin
                            blk_d[14] = len_field[63:32];
                            blk_d[15] = len_field[31:0];
                            last_d    = 1'b1;
                            pad_d     = PAD_NONE;
                        end else begin
                            last_d = 1'b0;
                            pad_d  = (pad_pos == 5'd16) ? PAD_MARK_LEN : PAD_LEN_ONLY;
                        end
                        word_idx_d = 4'd0;
                        state_d    = OUT;
                    end
                end
            end
            OUT: begin
                if (data_out_ready) begin
                    if (pad_q != PAD_NONE) begin
                        state_d = EXTRA;
                    end else begin
                        state_d    = COLLECT;
                        word_idx_d = 4'd0;
                        if (last_q) bit_len_d = '0;
                    end
                end
            end
            EXTRA: begin
                blk_d     = '0;
                blk_d[14] = len_field_q[63:32];
                blk_d[15] = len_field_q[31:0];
                if (pad_q == PAD_MARK_LEN) blk_d[0] = 32'h8000_0000;
                last_d  = 1'b1;
                pad_d   = PAD_NONE;
                state_d = OUT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // NOTE: the block register is reset as well, since data_out must read zero after reset.
    always_ff @(posedge clk) begin
        if (!nrst || sync_rst) begin
            state_q    <= COLLECT;
            pad_q      <= PAD_NONE;
            word_idx_q <= '0;
            bit_len_q  <= '0;
            blk_q      <= '0;
            last_q     <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all update together at the edge.
            state_q    <= state_d;
            pad_q      <= pad_d;
            word_idx_q <= word_idx_d;
            bit_len_q  <= bit_len_d;
            blk_q      <= blk_d;
            last_q     <= last_d;
        end
    end

    assign data_in_ready  = (state_q == COLLECT) && nrst && !sync_rst;
    assign data_out       = blk_q;
    assign data_out_last  = last_q;
    assign data_out_valid = (state_q == OUT);

endmodule

// File: tb/tb_message_build.sv
// Directed bench for message_build: expected blocks are queued as each message is sent
// and compared against the DUT output on every block handshake.
module tb_message_build;

    logic         clk = 1'b0;
    logic         nrst;
    logic         sync_rst;
    logic [31:0]  data_in;
    logic [1:0]   data_in_nbytes;
    logic         data_in_last;
    logic         data_in_valid;
    logic         data_in_ready;
    logic [511:0] data_out;
    logic         data_out_last;
    logic         data_out_valid;
    logic         data_out_ready;

    typedef struct {
        logic [511:0] data;
        logic         last;
    } blk_t;

    blk_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_blocks = 0;

    message_build #(.LEN_W(64)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .sync_rst       (sync_rst),
        .data_in        (data_in),
        .data_in_nbytes (data_in_nbytes),
        .data_in_last   (data_in_last),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_last  (data_out_last),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] put(input logic [511:0] b, input int k, input logic [31:0] w);
        logic [511:0] r;
        r = b;
        r[32*k +: 32] = w;
        return r;
    endfunction

    function automatic logic [31:0] pat(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    // Block consumer: every handshake pops one expected block.
    always @(negedge clk) begin
        if (data_out_valid && data_out_ready) begin
            blk_t e;
            n_blocks++;
            if (sb.size() == 0) begin
                check("unexpected_block", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                check("block_data", data_out, e.data);
                check("block_last", data_out_last, e.last);
            end
        end
    end

    task automatic send(input logic [31:0] w, input logic [1:0] nb, input logic last);
        int cnt = 0;
        data_in        = w;
        data_in_nbytes = nb;
        data_in_last   = last;
        data_in_valid  = 1'b1;
        forever begin
            @(negedge clk);
            if (data_in_ready) break;
            cnt++;
            if (cnt > 200) begin
                check("send_timeout", 1'b1, 1'b0);
                break;
            end
        end
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        data_in_last  = 1'b0;
    endtask

    task automatic drain();
        int cnt = 0;
        while (sb.size() != 0 && cnt < 200) begin
            @(posedge clk);
            cnt++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        blk_t         e;
        logic [511:0] b;
        logic [511:0] held;
        int           cnt;

        nrst = 1'b0; sync_rst = 1'b0; data_in = '0; data_in_nbytes = '0;
        data_in_last = 1'b0; data_in_valid = 1'b0; data_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", data_in_ready, 1'b0);
        check("rst_valid", data_out_valid, 1'b0);
        check("rst_last", data_out_last, 1'b0);
        check("rst_data", data_out, 512'd0);
        nrst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", data_in_ready, 1'b1);
        @(posedge clk);
        #1;

        // "abc"
        b = '0; b = put(b, 0, 32'h6162_6380); b = put(b, 15, 32'h0000_0018);
        e.data = b; e.last = 1'b1; sb.push_back(e);
        send(32'h6162_6300, 2'd3, 1'b1);
        check("abc_latency", data_out_valid, 1'b1);
        drain();

        // 14 full words, last on word 13
        b = '0;
        for (int i = 0; i < 14; i++) b = put(b, i, pat(i));
        b = put(b, 14, 32'h8000_0000);
        e.data = b; e.last = 1'b0; sb.push_back(e);
        b = '0; b = put(b, 15, 32'h0000_01C0);
        e.data = b; e.last = 1'b1; sb.push_back(e);
        for (int i = 0; i < 14; i++) send(pat(i), 2'd0, i == 13);
        drain();

        // 13 full words plus one byte
        b = '0;
        for (int i = 0; i < 13; i++) b = put(b, i, pat(i + 20));
        b = put(b, 13, 32'hAB80_0000); b = put(b, 15, 32'h0000_01A8);
        e.data = b; e.last = 1'b1; sb.push_back(e);
        for (int i = 0; i < 13; i++) send(pat(i + 20), 2'd0, 1'b0);
        send(32'hAB00_0000, 2'd1, 1'b1);
        drain();

        // 16 full words with backpressure on block 1
        b = '0;
        for (int i = 0; i < 16; i++) b = put(b, i, pat(i + 40));
        e.data = b; e.last = 1'b0; sb.push_back(e);
        b = '0; b = put(b, 0, 32'h8000_0000); b = put(b, 15, 32'h0000_0200);
        e.data = b; e.last = 1'b1; sb.push_back(e);
        data_out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(pat(i + 40), 2'd0, i == 15);
        check("bp_valid", data_out_valid, 1'b1);
        held = data_out;
        check("bp_block1", held, sb[0].data);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (data_out !== held || data_in_ready !== 1'b0 || data_out_valid !== 1'b1) cnt++;
        end
        check("bp_hold_cycles_bad", 32'(cnt), 32'd0);
        @(posedge clk);
        #1;
        data_out_ready = 1'b1;
        drain();

        // sync_rst after 7 words, then "abc"
        for (int i = 0; i < 7; i++) send(pat(i + 60), 2'd0, 1'b0);
        sync_rst = 1'b1;
        @(negedge clk);
        check("sync_rst_ready", data_in_ready, 1'b0);
        @(posedge clk);
        #1;
        sync_rst = 1'b0;
        b = '0; b = put(b, 0, 32'h6162_6380); b = put(b, 15, 32'h0000_0018);
        e.data = b; e.last = 1'b1; sb.push_back(e);
        send(32'h6162_6300, 2'd3, 1'b1);
        drain();

        check("block_count", 32'(n_blocks), 32'd7);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
